// File: rtl/bird_pkg.sv
// Shared types and default geometry for the bird motion block.
package bird_pkg;

  // Game phase as driven by the game controller; 2'b11 decodes as DEAD.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    DEAD = 2'b10
  } game_state_t;

  // Default sprite geometry and placement, in pixels.
  localparam int DEF_X_POS    = 320;
  localparam int DEF_Y_START  = 240;
  localparam int DEF_GROUND_Y = 440;
  localparam int DEF_SPRITE_W = 21;
  localparam int DEF_SPRITE_H = 13;
  localparam int DEF_ADDR_W   = 19;

  // Map the raw 2-bit game state onto the enum, folding 2'b11 into DEAD.
  function automatic game_state_t decode_state(input logic [1:0] raw);
    game_state_t st;
    case (raw)
      2'b00:   st = IDLE;
      2'b01:   st = PLAY;
      default: st = DEAD;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/bird_motion_if.sv
// Pixel/game-side signal bundle of the bird block.
// master = game/video side, slave = bird_motion.
interface bird_motion_if #(
  parameter int ADDR_W = 19,
  parameter int FIDX_W = 2
);
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              flap;
  logic [1:0]        game_state;
  logic [9:0]        bird_x;
  logic [9:0]        bird_y;
  logic              is_bird;
  logic [ADDR_W-1:0] sprite_addr;
  logic              hit_ground;
  logic              hit_ceiling;
  logic [FIDX_W-1:0] frame_idx;

  modport master (
    output DrawX, DrawY, flap, game_state,
    input  bird_x, bird_y, is_bird, sprite_addr, hit_ground, hit_ceiling, frame_idx
  );

  modport slave (
    input  DrawX, DrawY, flap, game_state,
    output bird_x, bird_y, is_bird, sprite_addr, hit_ground, hit_ceiling, frame_idx
  );
endinterface

// File: rtl/bird_anim_ctr.sv
// Wing-flap animation counter: advances the frame every FRAME_TICKS ticks
// while enabled, cleared back to frame 0 by a tick with clear set.
module bird_anim_ctr #(
  parameter int NUM_FRAMES  = 3,
  parameter int FRAME_TICKS = 4,
  parameter int FIDX_W      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              tick,
  input  logic              enable,
  input  logic              clear,
  output logic [FIDX_W-1:0] frame_idx
);

  localparam int CNT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(FRAME_TICKS - 1);
  localparam logic [FIDX_W-1:0] FRAME_LAST = FIDX_W'(NUM_FRAMES - 1);

  logic [CNT_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [FIDX_W-1:0] frame_idx_q, frame_idx_d;

  // Next tick count / frame; clear wins over enable, no change without tick.
  always_comb begin
    tick_cnt_d  = tick_cnt_q;
    frame_idx_d = frame_idx_q;
    if (tick && clear) begin
      tick_cnt_d  = '0;
      frame_idx_d = '0;
    end else if (tick && enable) begin
      if (tick_cnt_q == CNT_LAST) begin
        tick_cnt_d  = '0;
        frame_idx_d = (frame_idx_q == FRAME_LAST) ? '0 : frame_idx_q + FIDX_W'(1);
      end else begin
        tick_cnt_d  = tick_cnt_q + CNT_W'(1);
        frame_idx_d = frame_idx_q;
      end
    end else begin
      tick_cnt_d  = tick_cnt_q;
      frame_idx_d = frame_idx_q;
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      tick_cnt_q  <= '0;
      frame_idx_q <= '0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      frame_idx_q <= frame_idx_d;
    end
  end

  assign frame_idx = frame_idx_q;

endmodule

// File: rtl/bird_motion.sv
// Flappy-bird motion: fixed-point vertical physics stepped once per video
// frame, sticky ground/ceiling contact flags, wing animation and the
// per-pixel sprite hit/address lookup.
module bird_motion
  import bird_pkg::*;
#(
  parameter int X_POS       = DEF_X_POS,
  parameter int Y_START     = DEF_Y_START,
  parameter int GROUND_Y    = DEF_GROUND_Y,
  parameter int SPRITE_W    = DEF_SPRITE_W,
  parameter int SPRITE_H    = DEF_SPRITE_H,
  parameter int FRAC        = 4,
  parameter int GRAVITY     = 16,
  parameter int JUMP_VEL    = 128,
  parameter int MAX_FALL    = 96,
  parameter int NUM_FRAMES  = 3,
  parameter int FRAME_TICKS = 4,
  parameter int ADDR_W      = DEF_ADDR_W
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          frame_clk,
  bird_motion_if.slave  bus
);

  localparam int FIDX_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int VEL_W  = 10 + FRAC + 1;
  localparam int Y_W    = 10 + FRAC;
  localparam int SUM_W  = Y_W + 2;

  localparam logic [Y_W-1:0]          Y_START_FX = Y_W'(Y_START << FRAC);
  localparam logic [Y_W-1:0]          GROUND_FX  = Y_W'((GROUND_Y - SPRITE_H) << FRAC);
  localparam logic signed [SUM_W-1:0] GROUND_S   = {2'b00, GROUND_FX};
  localparam logic signed [VEL_W-1:0] GRAV_V     = VEL_W'(GRAVITY);
  localparam logic signed [VEL_W-1:0] JUMP_V     = VEL_W'(-JUMP_VEL);
  localparam logic signed [VEL_W-1:0] MAX_V      = VEL_W'(MAX_FALL);
  localparam logic [ADDR_W-1:0]       FRAME_PIX  = ADDR_W'(SPRITE_W * SPRITE_H);

  // frame_clk synchroniser: [0],[1] resynchronise, [2] is the edge history.
  logic [2:0]                fsync_q, fsync_d;
  logic                      tick_s;
  logic                      flap_prev_q, flap_prev_d;
  logic                      flap_rise_s;
  logic                      flap_pending_q, flap_pending_d;
  logic signed [VEL_W-1:0]   vel_q, vel_d;
  logic [Y_W-1:0]            y_fx_q, y_fx_d;
  logic                      hit_ground_q, hit_ground_d;
  logic                      hit_ceiling_q, hit_ceiling_d;
  game_state_t               state_s;

  logic signed [VEL_W-1:0]   vel_base_s;
  logic signed [VEL_W-1:0]   vel_grav_s;
  logic signed [VEL_W-1:0]   vel_new_s;
  logic signed [SUM_W-1:0]   vel_ext_s;
  logic signed [SUM_W-1:0]   y_sum_s;

  logic [FIDX_W-1:0]         frame_idx_s;
  logic [9:0]                bird_y_s;
  logic                      is_bird_s;
  logic [ADDR_W-1:0]         sprite_addr_s;
  logic                      in_x_s, in_y_s;
  logic [10:0]               draw_x_w, draw_y_w, y_top_w, y_bot_w;
  logic [9:0]                dx_s, dy_s;

  assign state_s     = decode_state(bus.game_state);
  assign tick_s      = fsync_q[1] & ~fsync_q[2];
  assign flap_rise_s = bus.flap & ~flap_prev_q;
  assign bird_y_s    = y_fx_q[Y_W-1:FRAC];

  // Shift frame_clk through the synchroniser chain and track flap history.
  always_comb begin
    fsync_d     = {fsync_q[1:0], frame_clk};
    flap_prev_d = bus.flap;
  end

  // A flap edge is latched only during play; every tick consumes it.
  always_comb begin
    if (flap_rise_s && (state_s == PLAY)) begin
      flap_pending_d = 1'b1;
    end else if (tick_s) begin
      flap_pending_d = 1'b0;
    end else begin
      flap_pending_d = flap_pending_q;
    end
  end

  // Candidate velocity and position for this tick. Once dead the bird may
  // only fall, so any remaining upward velocity is dropped before gravity.
  always_comb begin
    if ((state_s == DEAD) && vel_q[VEL_W-1]) begin
      vel_base_s = '0;
    end else begin
      vel_base_s = vel_q;
    end
    vel_grav_s = vel_base_s + GRAV_V;
    if ((state_s == PLAY) && flap_pending_q) begin
      vel_new_s = JUMP_V;
    end else if (vel_grav_s > MAX_V) begin
      vel_new_s = MAX_V;
    end else begin
      vel_new_s = vel_grav_s;
    end
    vel_ext_s = {{(SUM_W - VEL_W){vel_new_s[VEL_W-1]}}, vel_new_s};
    y_sum_s   = $signed({2'b00, y_fx_q}) + vel_ext_s;
  end

  // Per-tick physics update with ceiling/ground clamps and sticky flags.
  always_comb begin
    vel_d         = vel_q;
    y_fx_d        = y_fx_q;
    hit_ground_d  = hit_ground_q;
    hit_ceiling_d = hit_ceiling_q;
    if (tick_s) begin
      case (state_s)
        IDLE: begin
          y_fx_d        = Y_START_FX;
          vel_d         = '0;
          hit_ground_d  = 1'b0;
          hit_ceiling_d = 1'b0;
        end
        PLAY, DEAD: begin
          if (y_sum_s[SUM_W-1]) begin
            y_fx_d        = '0;
            vel_d         = '0;
            hit_ceiling_d = 1'b1;
          end else if (y_sum_s >= GROUND_S) begin
            y_fx_d       = GROUND_FX;
            vel_d        = '0;
            hit_ground_d = 1'b1;
          end else begin
            y_fx_d = y_sum_s[Y_W-1:0];
            vel_d  = vel_new_s;
          end
        end
        default: begin
          vel_d  = vel_q;
          y_fx_d = y_fx_q;
        end
      endcase
    end else begin
      vel_d  = vel_q;
      y_fx_d = y_fx_q;
    end
  end

  // Motion state registers; Reset overrides any coincident tick or flap.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fsync_q        <= 3'b000;
      flap_prev_q    <= 1'b0;
      flap_pending_q <= 1'b0;
      vel_q          <= '0;
      y_fx_q         <= Y_START_FX;
      hit_ground_q   <= 1'b0;
      hit_ceiling_q  <= 1'b0;
    end else begin
      fsync_q        <= fsync_d;
      flap_prev_q    <= flap_prev_d;
      flap_pending_q <= flap_pending_d;
      vel_q          <= vel_d;
      y_fx_q         <= y_fx_d;
      hit_ground_q   <= hit_ground_d;
      hit_ceiling_q  <= hit_ceiling_d;
    end
  end

  bird_anim_ctr #(
    .NUM_FRAMES  (NUM_FRAMES),
    .FRAME_TICKS (FRAME_TICKS),
    .FIDX_W      (FIDX_W)
  ) u_anim (
    .Clk       (Clk),
    .Reset     (Reset),
    .tick      (tick_s),
    .enable    (state_s == PLAY),
    .clear     (state_s == IDLE),
    .frame_idx (frame_idx_s)
  );

  // Sprite box hit test and ROM address for the current pixel (11-bit
  // arithmetic so the box edge near 1023 cannot wrap).
  always_comb begin
    draw_x_w = {1'b0, bus.DrawX};
    draw_y_w = {1'b0, bus.DrawY};
    y_top_w  = {1'b0, bird_y_s};
    y_bot_w  = y_top_w + 11'(SPRITE_H);
    in_x_s   = (draw_x_w >= 11'(X_POS)) && (draw_x_w < 11'(X_POS + SPRITE_W));
    in_y_s   = (draw_y_w >= y_top_w) && (draw_y_w < y_bot_w);
    dx_s     = bus.DrawX - 10'(X_POS);
    dy_s     = bus.DrawY - bird_y_s;
    if (in_x_s && in_y_s) begin
      is_bird_s     = 1'b1;
      sprite_addr_s = ADDR_W'(frame_idx_s) * FRAME_PIX
                    + ADDR_W'(dy_s) * ADDR_W'(SPRITE_W)
                    + ADDR_W'(dx_s);
    end else begin
      is_bird_s     = 1'b0;
      sprite_addr_s = '0;
    end
  end

  assign bus.bird_x      = 10'(X_POS);
  assign bus.bird_y      = bird_y_s;
  assign bus.is_bird     = is_bird_s;
  assign bus.sprite_addr = sprite_addr_s;
  assign bus.hit_ground  = hit_ground_q;
  assign bus.hit_ceiling = hit_ceiling_q;
  assign bus.frame_idx   = frame_idx_s;

endmodule
